// File: rtl/yarp_pkg.sv
// Shared definitions for the YARP core: datapath width and fetch FSM states.
package yarp_pkg;

    parameter int unsigned XLEN = 32;

    // RISC-V canonical NOP (addi x0, x0, 0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/yarp_fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
interface yarp_fetch_if;
    import yarp_pkg::*;

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [31:0]     imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );

endinterface

// File: rtl/yarp_fetch.sv
// Instruction fetch stage: one outstanding request, registered instruction buffer,
// redirect handling with in-flight response kill.
// Optional: define YARP_FETCH_MISALIGN_CHECK_EN to flag and align misaligned redirects.
module yarp_fetch
    import yarp_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_1000
) (
    input  logic             clk,
    input  logic             reset_n,
    yarp_fetch_if.master     imem,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    output logic             instr_valid_o,
    output logic [31:0]      instr_o,
    output logic [XLEN-1:0]  pc_o,
    input  logic             instr_ready_i,
    output logic             misalign_o
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic            kill_q;
    logic [XLEN-1:0] redirect_target;
    logic            redirect_misaligned;

`ifdef YARP_FETCH_MISALIGN_CHECK_EN
    assign redirect_target     = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign redirect_misaligned = (redirect_pc_i[1:0] != 2'b00);
`else
    assign redirect_target     = redirect_pc_i;
    assign redirect_misaligned = 1'b0;
`endif

    // Request is a pure decode of the state register; address is always pc_q
    assign imem.imem_req_o  = (state_q == REQ);
    assign imem.imem_addr_o = pc_q;

    // Fetch FSM with registered instruction buffer; redirect overrides everything
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            kill_q        <= 1'b0;
            instr_valid_o <= 1'b0;
            instr_o       <= NOP_INSTR;
            pc_o          <= RESET_PC;
            misalign_o    <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            if (redirect_i) begin
                pc_q          <= redirect_target;
                instr_valid_o <= 1'b0;
                misalign_o    <= redirect_misaligned;
                unique case (state_q)
                    IDLE, HOLD: begin
                        state_q <= REQ;
                        kill_q  <= 1'b0;
                    end
                    REQ: begin
                        // A granted request has a response in flight that must be dropped
                        if (imem.imem_gnt_i) begin
                            state_q <= WAIT;
                            kill_q  <= 1'b1;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                    WAIT: begin
                        if (imem.imem_rvalid_i) begin
                            state_q <= REQ;
                            kill_q  <= 1'b0;
                        end else begin
                            kill_q  <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else begin
                unique case (state_q)
                    IDLE: state_q <= REQ;
                    REQ: begin
                        if (imem.imem_gnt_i) begin
                            state_q <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (imem.imem_rvalid_i) begin
                            if (kill_q) begin
                                kill_q  <= 1'b0;
                                state_q <= REQ;
                            end else begin
                                instr_o       <= imem.imem_rdata_i;
                                pc_o          <= pc_q;
                                instr_valid_o <= 1'b1;
                                state_q       <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (instr_ready_i) begin
                            pc_q          <= pc_q + XLEN'(4);
                            instr_valid_o <= 1'b0;
                            state_q       <= REQ;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_yarp_fetch.sv
// Directed self-checking bench for yarp_fetch.
module tb_yarp_fetch;
    import yarp_pkg::*;

    logic            clk;
    logic            reset_n;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            instr_valid_o;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] pc_o;
    logic            instr_ready_i;
    logic            misalign_o;

    int unsigned n_tests;
    int unsigned n_fail;

    yarp_fetch_if imem ();

    yarp_fetch #(
        .RESET_PC (32'h0000_1000)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem          (imem.master),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_ready_i (instr_ready_i),
        .misalign_o    (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From REQ at expected address: grant, then respond next cycle; ends in HOLD
    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check({tag, "_req"}, 32'(imem.imem_req_o), 32'd1);
        check({tag, "_addr"}, imem.imem_addr_o, addr);
        imem.imem_gnt_i = 1'b1;
        step();
        imem.imem_gnt_i    = 1'b0;
        imem.imem_rvalid_i = 1'b1;
        imem.imem_rdata_i  = data;
        check({tag, "_wait_noreq"}, 32'(imem.imem_req_o), 32'd0);
        step();
        imem.imem_rvalid_i = 1'b0;
        check({tag, "_valid"}, 32'(instr_valid_o), 32'd1);
        check({tag, "_instr"}, instr_o, data);
        check({tag, "_pc"}, pc_o, addr);
    endtask

    initial begin
        logic [31:0] exp_mis;
        logic [31:0] exp_mis_addr;
        n_tests = 0;
        n_fail  = 0;
        reset_n            = 1'b0;
        redirect_i         = 1'b0;
        redirect_pc_i      = '0;
        instr_ready_i      = 1'b0;
        imem.imem_gnt_i    = 1'b0;
        imem.imem_rvalid_i = 1'b0;
        imem.imem_rdata_i  = '0;

        step();
        step();
        check("rst_req", 32'(imem.imem_req_o), 32'd0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'h0000_0013);
        check("rst_pc", pc_o, 32'h0000_1000);
        check("rst_mis", 32'(misalign_o), 32'd0);

        reset_n = 1'b1;
        step(); // IDLE -> REQ
        fetch("first", 32'h0000_1000, 32'h0050_0093);

        // Decode stalls: buffer stable, no new request
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_instr", instr_o, 32'h0050_0093);
            check("hold_pc", pc_o, 32'h0000_1000);
            check("hold_noreq", 32'(imem.imem_req_o), 32'd0);
        end
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
        check("hs_valid", 32'(instr_valid_o), 32'd0);
        check("hs_addr", imem.imem_addr_o, 32'h0000_1004);
        check("hs_req", 32'(imem.imem_req_o), 32'd1);

        // Stray response in REQ is ignored
        imem.imem_rvalid_i = 1'b1;
        imem.imem_rdata_i  = 32'hBAD0_BAD0;
        step();
        imem.imem_rvalid_i = 1'b0;
        check("stray_valid", 32'(instr_valid_o), 32'd0);
        check("stray_req", 32'(imem.imem_req_o), 32'd1);

        // Redirect while waiting: response killed
        imem.imem_gnt_i = 1'b1;
        step();
        imem.imem_gnt_i = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_2000;
        step();
        redirect_i = 1'b0;
        check("kill_wait_noreq", 32'(imem.imem_req_o), 32'd0);
        imem.imem_rvalid_i = 1'b1;
        imem.imem_rdata_i  = 32'hDEAD_BEEF;
        step();
        imem.imem_rvalid_i = 1'b0;
        check("kill_valid", 32'(instr_valid_o), 32'd0);
        check("kill_addr", imem.imem_addr_o, 32'h0000_2000);
        check("kill_req", 32'(imem.imem_req_o), 32'd1);

        // Redirect in REQ without grant retargets the request
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_1008;
        step();
        redirect_i = 1'b0;
        fetch("f1008", 32'h0000_1008, 32'h0000_0113);

        // Redirect coinciding with handshake wins over pc+4
        instr_ready_i = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_3000;
        step();
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        check("rdhs_addr", imem.imem_addr_o, 32'h0000_3000);
        check("rdhs_valid", 32'(instr_valid_o), 32'd0);

        // pc wrap
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        fetch("ftop", 32'hFFFF_FFFC, 32'h0000_0193);
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
        check("wrap_addr", imem.imem_addr_o, 32'h0000_0000);

        // Redirect coinciding with grant: response still in flight is killed
        imem.imem_gnt_i = 1'b1;
        redirect_i      = 1'b1;
        redirect_pc_i   = 32'h0000_4000;
        step();
        imem.imem_gnt_i = 1'b0;
        redirect_i      = 1'b0;
        check("rdgnt_noreq", 32'(imem.imem_req_o), 32'd0);
        imem.imem_rvalid_i = 1'b1;
        step();
        imem.imem_rvalid_i = 1'b0;
        check("rdgnt_valid", 32'(instr_valid_o), 32'd0);
        check("rdgnt_addr", imem.imem_addr_o, 32'h0000_4000);

        // Redirect coinciding with the response
        imem.imem_gnt_i = 1'b1;
        step();
        imem.imem_gnt_i    = 1'b0;
        imem.imem_rvalid_i = 1'b1;
        redirect_i         = 1'b1;
        redirect_pc_i      = 32'h0000_5000;
        step();
        imem.imem_rvalid_i = 1'b0;
        redirect_i         = 1'b0;
        check("rdrv_valid", 32'(instr_valid_o), 32'd0);
        check("rdrv_addr", imem.imem_addr_o, 32'h0000_5000);
        check("rdrv_req", 32'(imem.imem_req_o), 32'd1);

        // Misaligned redirect
`ifdef YARP_FETCH_MISALIGN_CHECK_EN
        exp_mis      = 32'd1;
        exp_mis_addr = 32'h0000_2000;
`else
        exp_mis      = 32'd0;
        exp_mis_addr = 32'h0000_2002;
`endif
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_2002;
        step();
        redirect_i = 1'b0;
        check("mis_flag", 32'(misalign_o), exp_mis);
        check("mis_addr", imem.imem_addr_o, exp_mis_addr);
        step();
        check("mis_pulse_end", 32'(misalign_o), 32'd0);

        // Reset mid-transaction, late response after release is ignored
        imem.imem_gnt_i = 1'b1;
        step();
        imem.imem_gnt_i = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mrst_req", 32'(imem.imem_req_o), 32'd0);
        check("mrst_pc", pc_o, 32'h0000_1000);
        check("mrst_instr", instr_o, 32'h0000_0013);
        step();
        reset_n = 1'b1;
        imem.imem_rvalid_i = 1'b1;
        imem.imem_rdata_i  = 32'hFEED_F00D;
        step();
        imem.imem_rvalid_i = 1'b0;
        check("late_valid", 32'(instr_valid_o), 32'd0);
        check("late_req", 32'(imem.imem_req_o), 32'd1);
        check("late_addr", imem.imem_addr_o, 32'h0000_1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
